// File: rtl/spi_slave_ram.sv
// Command-decoding byte RAM behind spi_slave; SPI_RAM_AUTO_INC_EN adds address post-increment.
// Latency: writes land at the rx_valid edge, reads/seq_err one cycle later; no backpressure, every frame is consumed.
module spi_slave_ram #(
   parameter int MEM_DEPTH  = 256,
   parameter int ADDR_width = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_width+1:0] rx_data,
   input  logic                  rx_valid,
   output logic [ADDR_width-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  seq_err
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;

   // Bit 0 = write address captured, bit 1 = read address captured.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      W    = 2'b01,
      R    = 2'b10,
      WR   = 2'b11
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_width-1:0] wr_addr, wr_addr_nxt;
   logic [ADDR_width-1:0] rd_addr, rd_addr_nxt;
   logic [ADDR_width-1:0] payload;
   logic [1:0]            cmd;
   logic                  in_range;
   logic                  have_wr;
   logic                  have_rd;
   logic                  mem_we;
   logic                  rd_go;
   logic                  err;

   logic [ADDR_width-1:0] mem [MEM_DEPTH];

   assign cmd      = rx_data[ADDR_width+1:ADDR_width];
   assign payload  = rx_data[ADDR_width-1:0];
   assign in_range = (32'(payload) < MEM_DEPTH);
   assign have_wr  = (state == W) || (state == WR);
   assign have_rd  = (state == R) || (state == WR);

`ifdef SPI_RAM_AUTO_INC_EN
   function automatic logic [ADDR_width-1:0] addr_inc(input logic [ADDR_width-1:0] a);
      return (32'(a) == MEM_DEPTH - 1) ? '0 : a + ADDR_width'(1);
   endfunction
`endif

   always_comb begin
      state_nxt   = state;
      wr_addr_nxt = wr_addr;
      rd_addr_nxt = rd_addr;
      mem_we      = 1'b0;
      rd_go       = 1'b0;
      err         = 1'b0;
      if (rx_valid) begin
         case (cmd)
            CMD_WR_ADDR: begin
               if (in_range) begin
                  wr_addr_nxt = payload;
                  if (state == IDLE)   state_nxt = W;
                  else if (state == R) state_nxt = WR;
               end else begin
                  err = 1'b1;
               end
            end
            CMD_RD_ADDR: begin
               if (in_range) begin
                  rd_addr_nxt = payload;
                  if (state == IDLE)   state_nxt = R;
                  else if (state == W) state_nxt = WR;
               end else begin
                  err = 1'b1;
               end
            end
            CMD_WR_DATA: begin
               if (have_wr) begin
                  mem_we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                  wr_addr_nxt = addr_inc(wr_addr);
`endif
               end else begin
                  err = 1'b1;
               end
            end
            default: begin
               if (have_rd) begin
                  rd_go = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                  rd_addr_nxt = addr_inc(rd_addr);
`endif
               end else begin
                  err = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wr_addr  <= '0;
         rd_addr  <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         seq_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wr_addr  <= wr_addr_nxt;
         rd_addr  <= rd_addr_nxt;
         tx_valid <= rd_go;
         seq_err  <= err;
         if (rd_go) tx_data <= mem[rd_addr[IDX_W-1:0]];
      end
   end

   // Storage is deliberately left out of reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[wr_addr[IDX_W-1:0]] <= payload;
   end

endmodule

// File: tb/tb_spi_slave_ram.sv
// Randomized and directed bench for spi_slave_ram against a flag/array reference model.
module tb_spi_slave_ram;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] rx_data, rx_data_s;
   logic       rx_valid, rx_valid_s;
   logic [7:0] tx_data, tx_data_s;
   logic       tx_valid, tx_valid_s;
   logic       seq_err, seq_err_s;

   int checks   = 0;
   int failures = 0;

`ifdef SPI_RAM_AUTO_INC_EN
   localparam bit AUTO_INC = 1'b1;
`else
   localparam bit AUTO_INC = 1'b0;
`endif
   localparam int DEPTH = 256;

   always #5 clk = ~clk;

   spi_slave_ram #(.MEM_DEPTH(256), .ADDR_width(8)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .seq_err(seq_err)
   );

   spi_slave_ram #(.MEM_DEPTH(128), .ADDR_width(8)) dut_s (
      .clk(clk), .rst(rst), .rx_data(rx_data_s), .rx_valid(rx_valid_s),
      .tx_data(tx_data_s), .tx_valid(tx_valid_s), .seq_err(seq_err_s)
   );

   // Reference model: address-valid flags, addresses, byte array (-1 = never written).
   int m_mem [DEPTH];
   bit m_hw, m_hr;
   int m_wa, m_ra;
   bit exp_txv, exp_err;
   int exp_txd;

   task automatic model_reset();
      m_hw = 0; m_hr = 0; m_wa = 0; m_ra = 0;
      exp_txv = 0; exp_err = 0; exp_txd = 0;
   endtask

   task automatic model_apply(input logic v, input logic [9:0] f);
      int p;
      p = int'(f[7:0]);
      exp_txv = 0;
      exp_err = 0;
      if (!v) return;
      case (f[9:8])
         2'd0: if (p >= DEPTH) exp_err = 1; else begin m_wa = p; m_hw = 1; end
         2'd2: if (p >= DEPTH) exp_err = 1; else begin m_ra = p; m_hr = 1; end
         2'd1: begin
            if (!m_hw) exp_err = 1;
            else begin
               m_mem[m_wa] = p;
               if (AUTO_INC) m_wa = (m_wa + 1) % DEPTH;
            end
         end
         default: begin
            if (!m_hr) exp_err = 1;
            else begin
               exp_txv = 1;
               exp_txd = m_mem[m_ra];
               if (AUTO_INC) m_ra = (m_ra + 1) % DEPTH;
            end
         end
      endcase
   endtask

   // Drive one frame (or idle cycle) from a negedge; return at the next negedge with outputs settled.
   task automatic step(input logic v, input logic [9:0] f);
      model_apply(v, f);
      rx_valid = v;
      rx_data  = f;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rx_valid = 0; rx_valid_s = 0;
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1;
      rx_valid = 0; rx_valid_s = 0; rx_data = '0; rx_data_s = '0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
      checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL reset_seq_err got=%b exp=0", seq_err); end
      checks++; if (tx_data_s !== 8'h00) begin failures++; $display("FAIL reset_tx_data_s got=%h exp=00", tx_data_s); end
      rst = 0;
      model_reset();
   endtask

   task automatic test_basic();
      logic [9:0] fr [4];
      fr = '{10'h005, 10'h1A7, 10'h205, 10'h300};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, fr[i]);
         checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL basic_seq_err i=%0d got=%b exp=0", i, seq_err); end
         checks++; if (tx_valid !== exp_txv) begin failures++; $display("FAIL basic_tx_valid i=%0d got=%b exp=%b", i, tx_valid, exp_txv); end
      end
      checks++; if (tx_data !== 8'hA7) begin failures++; $display("FAIL basic_tx_data got=%h exp=a7", tx_data); end
      step(1'b0, 10'h000);
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL basic_tx_valid_width got=%b exp=0", tx_valid); end
      checks++; if (tx_data !== 8'hA7) begin failures++; $display("FAIL basic_tx_data_hold got=%h exp=a7", tx_data); end
   endtask

   task automatic test_seq_err();
      step(1'b1, 10'h000);
      step(1'b1, 10'h13C);
      step(1'b0, 10'h000);
      do_reset();
      step(1'b1, 10'h155);
      checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL seqerr_wr_idle got=%b exp=1", seq_err); end
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL seqerr_wr_txv got=%b exp=0", tx_valid); end
      step(1'b1, 10'h300);
      checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL seqerr_rd_idle got=%b exp=1", seq_err); end
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL seqerr_rd_txv got=%b exp=0", tx_valid); end
      step(1'b1, 10'h200);
      checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL seqerr_clear got=%b exp=0", seq_err); end
      step(1'b1, 10'h300);
      checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL seqerr_readback_v got=%b exp=1", tx_valid); end
      checks++; if (tx_data !== 8'h3C) begin failures++; $display("FAIL seqerr_mem_unchanged got=%h exp=3c", tx_data); end
      step(1'b0, 10'h000);
   endtask

   task automatic test_range();
      logic [9:0] fr [10];
      logic       e_err [10];
      logic       e_txv [10];
      fr    = '{10'h0C8, 10'h13C, 10'h00A, 10'h15A, 10'h0C8, 10'h177, 10'h280, 10'h20A, 10'h300, 10'h27F};
      e_err = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 0};
      e_txv = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         rx_data_s  = fr[i];
         rx_valid_s = 1'b1;
         @(negedge clk);
         checks++; if (seq_err_s !== e_err[i]) begin failures++; $display("FAIL range_seq_err i=%0d got=%b exp=%b", i, seq_err_s, e_err[i]); end
         checks++; if (tx_valid_s !== e_txv[i]) begin failures++; $display("FAIL range_tx_valid i=%0d got=%b exp=%b", i, tx_valid_s, e_txv[i]); end
      end
      checks++; if (tx_data_s !== 8'h77) begin failures++; $display("FAIL range_tx_data got=%h exp=77", tx_data_s); end
      rx_valid_s = 1'b0;
      @(negedge clk);
      checks++; if (seq_err_s !== 1'b0) begin failures++; $display("FAIL range_idle_err got=%b exp=0", seq_err_s); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1'b1, 10'h003);
      step(1'b1, 10'h15B);
      step(1'b1, 10'h203);
      rx_data  = 10'h300;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rst = 1;
      rx_valid = 0;
      @(negedge clk);
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL midrst_tx_valid got=%b exp=0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL midrst_tx_data got=%h exp=00", tx_data); end
      checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL midrst_seq_err got=%b exp=0", seq_err); end
      @(negedge clk);
      rst = 0;
      model_reset();
      step(1'b1, 10'h300);
      checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL midrst_after_err got=%b exp=1", seq_err); end
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL midrst_after_txv got=%b exp=0", tx_valid); end
      step(1'b0, 10'h000);
   endtask

   task automatic test_back_to_back();
      logic [9:0] fr [6];
      logic [7:0] got [$];
      fr = '{10'h0FF, 10'h111, 10'h122, 10'h2FF, 10'h300, 10'h300};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         if (i < 6) step(1'b1, fr[i]); else step(1'b0, 10'h000);
         checks++; if (seq_err !== exp_err) begin failures++; $display("FAIL b2b_seq_err i=%0d got=%b exp=%b", i, seq_err, exp_err); end
         checks++; if (tx_valid !== exp_txv) begin failures++; $display("FAIL b2b_tx_valid i=%0d got=%b exp=%b", i, tx_valid, exp_txv); end
         if (tx_valid === 1'b1) got.push_back(tx_data);
      end
      checks++; if (got.size() !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", got.size()); end
      if (got.size() == 2) begin
         checks++; if (got[0] !== (AUTO_INC ? 8'h11 : 8'h22)) begin failures++; $display("FAIL b2b_first got=%h exp=%h", got[0], AUTO_INC ? 8'h11 : 8'h22); end
         checks++; if (got[1] !== 8'h22) begin failures++; $display("FAIL b2b_second got=%h exp=22", got[1]); end
      end
   endtask

   task automatic test_random();
      logic       v;
      logic [1:0] c;
      logic [9:0] f;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         v = ($urandom_range(0, 4) != 0);
         c = 2'($urandom_range(0, 3));
         f = {c, 8'($urandom_range(0, 15))};
         if ($urandom_range(0, 7) == 0) f[7:0] = 8'($urandom);
         step(v, f);
         checks++; if (seq_err !== exp_err) begin failures++; $display("FAIL rand_seq_err i=%0d got=%b exp=%b", i, seq_err, exp_err); end
         checks++; if (tx_valid !== exp_txv) begin failures++; $display("FAIL rand_tx_valid i=%0d got=%b exp=%b", i, tx_valid, exp_txv); end
         if (exp_txd >= 0) begin
            checks++; if (tx_data !== exp_txd[7:0]) begin failures++; $display("FAIL rand_tx_data i=%0d got=%h exp=%h", i, tx_data, exp_txd[7:0]); end
         end
      end
      step(1'b0, 10'h000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (m_mem[i]) m_mem[i] = -1;
      rst = 1;
      test_reset();
      test_basic();
      test_seq_err();
      test_range();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_slave_ram.md
Name: spi_slave_ram

Overview:
- Command-decoding single-port memory directly downstream of spi_slave.
- Consumes each completed 10-bit frame (rx_data/rx_valid) and decodes bits [9:8] as a command.
- Stores and fetches bytes; returns read bytes to spi_slave via tx_data/tx_valid for shifting out on miso.
- Sits in the same spi_slave_io-connected subsystem as spi_slave.

Parameters:
- MEM_DEPTH, 256, number of byte locations.
- ADDR_width, 8, address width; also the data byte width carried in rx_data[7:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- rx_data  input  ADDR_width+2  frame from spi_slave; [9:8] command, [7:0] payload.
- rx_valid  input  1  one-cycle strobe: rx_data is valid.
- tx_data  output  ADDR_width  read byte to spi_slave.
- tx_valid  output  1  one-cycle strobe: tx_data is valid.
- seq_err  output  1  one-cycle strobe: frame rejected.

Behaviour:
- Reset (asynchronous, rst=1):
  - tx_data=0, tx_valid=0, seq_err=0.
  - wr_addr=0, rd_addr=0; state=IDLE.
  - Memory contents are not cleared.
- Commands (rx_data[9:8]), sampled only on cycles where rx_valid=1:
  - 00 WR_ADDR: wr_addr<=payload; write-address-valid flag set.
  - 01 WR_DATA: mem[wr_addr]<=payload.
  - 10 RD_ADDR: rd_addr<=payload; read-address-valid flag set.
  - 11 RD_DATA: payload ignored; fetch mem[rd_addr].
- State machine. States encode the two valid flags:
  - IDLE: no address captured.
  - W: only write address captured.
  - R: only read address captured.
  - WR: both captured.
  - WR_ADDR moves IDLE->W and R->WR. RD_ADDR moves IDLE->R and W->WR.
  - Data commands never change the state.
  - Only rst returns the block to IDLE.
- Latency:
  - WR_DATA: memory updated at the rx_valid edge.
  - RD_DATA: tx_data=mem[rd_addr] and tx_valid=1 on the cycle after the rx_valid cycle.
  - tx_valid lasts exactly 1 cycle. tx_data then holds its value until the next successful read.
- Read-after-write: RD_DATA issued the cycle after a WR_DATA to the same address returns the new byte.
- Errors. seq_err pulses the cycle after rx_valid, and the frame has no effect on memory, addresses, tx_valid or tx_data, when:
  - WR_DATA arrives in IDLE or R;
  - RD_DATA arrives in IDLE or W;
  - an address payload >= MEM_DEPTH (address registers unchanged).
- rx_valid=0: inputs ignored; all strobes 0.
- Back-to-back frames: rx_valid on consecutive cycles is legal; each frame is processed independently with the latencies above.
- Reset mid-operation:
  - A pending tx_valid or seq_err pulse is cancelled.
  - After reset, a data command before any address command raises seq_err.

Optional Feature:
- Macro: SPI_RAM_AUTO_INC_EN.
- Defined:
  - Each accepted WR_DATA post-increments wr_addr; each accepted RD_DATA post-increments rd_addr.
  - Increment wraps from MEM_DEPTH-1 to 0.
  - Rejected frames do not increment.
- Not defined: addresses change only on WR_ADDR/RD_ADDR; repeated data commands hit the same location.

Test Plan:
- Basic write/read: rst pulse; frames 0x005 (WR_ADDR 5), 0x1A7 (WR_DATA A7), 0x205 (RD_ADDR 5), 0x300 (RD_DATA) -> tx_valid=1 for one cycle, one cycle after the last rx_valid, with tx_data=0xA7; seq_err never asserted.
- Sequence error: after rst, send 0x155 (WR_DATA) then 0x300 (RD_DATA) -> seq_err pulses twice; tx_valid stays 0; memory unchanged.
- Out-of-range address: MEM_DEPTH=128, send 0x0C8 (WR_ADDR 200) -> seq_err pulse. Then 0x13C (WR_DATA) -> seq_err pulse; memory unchanged.
- Reset mid-operation: WR_ADDR 3, RD_ADDR 3, rx_valid=RD_DATA, rst asserted on the next cycle -> no tx_valid pulse; tx_data=0. A following 0x300 -> seq_err.
- Back-to-back with SPI_RAM_AUTO_INC_EN:
  - Stimulus: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 on consecutive cycles, then RD_ADDR 0xFF, RD_DATA, RD_DATA.
  - Required: mem[255]=0x11, mem[0]=0x22 (wrap); tx_data=0x11 then 0x22 on consecutive tx_valid pulses.
- Same auto-increment stimulus without the macro: both writes land in mem[255], which holds 0x22; both reads return 0x22.
